// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and requester ids for the register-file writeback controller.
package regfile_ctrl_pkg;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  // Bit position of each requester in the valid/grant vectors.
  typedef enum logic {REQ_ALU = 1'b0, REQ_LOAD = 1'b1} req_id_e;
endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the port that did not win last time wins.
module rr_arb2
  import regfile_ctrl_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_e    last,
  output logic [1:0] gnt,
  output logic       upd
);

  // Single requester wins outright; a tie goes to the port opposite to last.
  always_comb begin
    gnt = valid;
    if (valid == 2'b11)
      gnt = (last == REQ_ALU) ? 2'b10 : 2'b01;
    upd = |gnt;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-port controller and scoreboard: arbitrates ALU/load writebacks onto the
// register-file write port and stalls issue on RAW/WAW against outstanding writes.
module regfile_wb_ctrl #(
  parameter int NREG = regfile_ctrl_pkg::NREG,
  parameter int AW   = regfile_ctrl_pkg::AW,
  parameter int DW   = regfile_ctrl_pkg::DW
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_iss_valid,
  input  logic [AW-1:0]   i_iss_rs1,
  input  logic [AW-1:0]   i_iss_rs2,
  input  logic [AW-1:0]   i_iss_rd,
  input  logic            i_iss_rd_we,
  output logic            o_iss_stall,
  input  logic            i_wba_valid,
  input  logic [AW-1:0]   i_wba_addr,
  input  logic [DW-1:0]   i_wba_data,
  input  logic            i_wbb_valid,
  input  logic [AW-1:0]   i_wbb_addr,
  input  logic [DW-1:0]   i_wbb_data,
  output logic            o_wba_ready,
  output logic            o_wbb_ready,
  output logic            o_rf_we,
  output logic [AW-1:0]   o_rf_waddr,
  output logic [DW-1:0]   o_rf_wdata,
  output logic [NREG-1:0] o_busy,
  output logic            o_err
);
  import regfile_ctrl_pkg::*;

  logic [NREG-1:0] busy, busy_nxt;
  req_id_e         last;
  logic [1:0]      gnt;
  logic            upd, xfer, accept;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_arb2 u_arb (
    .valid ({i_wbb_valid, i_wba_valid}),
    .last  (last),
    .gnt   (gnt),
    .upd   (upd)
  );

  // Hazard check against the current mask; nothing is granted or stalled in reset.
  always_comb begin
    o_iss_stall = !i_rst && i_iss_valid &&
                  (busy[i_iss_rs1] || busy[i_iss_rs2] || (i_iss_rd_we && busy[i_iss_rd]));
    accept      = !i_rst && i_iss_valid && !o_iss_stall;
    o_wba_ready = !i_rst && gnt[REQ_ALU];
    o_wbb_ready = !i_rst && gnt[REQ_LOAD];
    xfer        = !i_rst && upd;
    sel_addr    = gnt[REQ_LOAD] ? i_wbb_addr : i_wba_addr;
    sel_data    = gnt[REQ_LOAD] ? i_wbb_data : i_wba_data;
  end

  // Next mask: clear the committing register, then mark the newly issued one.
  always_comb begin
    busy_nxt = busy;
    if (o_rf_we)
      busy_nxt[o_rf_waddr] = 1'b0;
    if (accept && i_iss_rd_we && (i_iss_rd != '0))
      busy_nxt[i_iss_rd] = 1'b1;
  end

  // r0 is never tracked.
  assign o_busy = {busy[NREG-1:1], 1'b0};

  // Write stage, arbiter pointer, scoreboard and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy       <= '0;
      last       <= REQ_LOAD;
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
      o_err      <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (o_rf_we && !busy[o_rf_waddr])
        o_err <= 1'b1;
      if (xfer) begin
        last       <= gnt[REQ_LOAD] ? REQ_LOAD : REQ_ALU;
        o_rf_we    <= (sel_addr != '0);
        o_rf_waddr <= sel_addr;
        o_rf_wdata <= sel_data;
      end else begin
        o_rf_we    <= 1'b0;
      end
    end
  end

endmodule
